// File: rtl/it_block_ctrl.sv
// it_block_ctrl: Thumb-2 IT block sequencer for the decode stage.
// Holds ITSTATE, advances it once per valid instruction, and evaluates the
// current condition against the APSR flags to decide execute vs. skip.
//
// Handshake: there is no backpressure. inst_valid marks the one cycle in
// which an instruction is presented; every combinational output describes
// that instruction. ITSTATE only moves on a cycle with inst_valid=1 (or on
// it_wr / flush / rst). A stall of any length with inst_valid=0 holds it.
//
// State: the block has two implicit states. IDLE is itstate[3:0]==0 and
// IN_BLK is anything else. in_it_blk exposes that state directly, and
// itstate exposes the full register.
module it_block_ctrl #(
  parameter logic [3:0] COND_AL = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_valid,
  input  logic       it_load,
  input  logic [3:0] it_firstcond,
  input  logic [3:0] it_mask,
  input  logic [4:0] apsr,
  input  logic       flush,
  input  logic       it_wr,
  input  logic [7:0] it_wr_data,
  output logic [7:0] itstate,
  output logic       in_it_blk,
  output logic [3:0] cur_cond,
  output logic       cond_pass,
  output logic       skip_inst,
  output logic       it_last,
  output logic [2:0] it_remain,
  output logic       it_err
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic unused_q;
  logic load_bad;
  logic al_mask_bad;

  assign flag_n   = apsr[4];
  assign flag_z   = apsr[3];
  assign flag_c   = apsr[2];
  assign flag_v   = apsr[1];
  assign unused_q = apsr[0];

  assign in_it_blk = (itstate[3:0] != 4'b0000);
  assign cur_cond  = in_it_blk ? itstate[7:4] : COND_AL;
  assign it_last   = in_it_blk && (itstate[2:0] == 3'b000);

  // The IT instruction itself is never turned into a NOP, even inside a block.
  assign skip_inst = inst_valid && !it_load && in_it_blk && !cond_pass;

  // AL may only be used with an all-"then" block: mask must have a single set bit.
  assign al_mask_bad = ((it_mask & (it_mask - 4'd1)) != 4'b0000);
  assign load_bad    = in_it_blk || (it_firstcond == 4'b1111) ||
                       ((it_firstcond == 4'b1110) && al_mask_bad);

  // Condition evaluation against the live flags (no snapshot at block start).
  always_comb begin
    cond_pass = 1'b1;
    case (cur_cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      default: cond_pass = 1'b1;
    endcase
  end

  // Instructions left including the current one, from the terminator position.
  always_comb begin
    it_remain = 3'd0;
    if (itstate[0])      it_remain = 3'd4;
    else if (itstate[1]) it_remain = 3'd3;
    else if (itstate[2]) it_remain = 3'd2;
    else if (itstate[3]) it_remain = 3'd1;
  end

  // ITSTATE update in priority order: rst, it_wr, flush, load, advance, hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      itstate <= 8'h00;
      it_err  <= 1'b0;
    end else begin
      it_err <= 1'b0;
      if (it_wr) begin
        itstate <= it_wr_data;
      end else if (flush) begin
        itstate <= 8'h00;
      end else if (inst_valid && it_load) begin
        if (load_bad) begin
          itstate <= 8'h00;
          it_err  <= 1'b1;
        end else begin
          itstate <= {it_firstcond, it_mask};
        end
      end else if (inst_valid && in_it_blk) begin
        if (itstate[2:0] == 3'b000) begin
          itstate <= 8'h00;
        end else begin
          itstate[4:0] <= {itstate[3:0], 1'b0};
        end
      end
    end
  end

endmodule
